// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: inst bit map and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package core_pkg;

    localparam int INST_W         = 34;
    localparam int INST_ACC       = 33;
    localparam int INST_CEN_PMEM  = 32;
    localparam int INST_WEN_PMEM  = 31;
    localparam int INST_APMEM_MSB = 30;
    localparam int INST_APMEM_LSB = 20;
    localparam int INST_CEN_XMEM  = 19;
    localparam int INST_WEN_XMEM  = 18;
    localparam int INST_AXMEM_MSB = 17;
    localparam int INST_AXMEM_LSB = 7;
    localparam int INST_OFIFO_RD  = 6;
    localparam int INST_L0_RD     = 3;
    localparam int INST_L0_WR     = 2;
    localparam int INST_EXEC      = 1;
    localparam int INST_LOAD      = 0;

    // Quiescent word: both SRAMs deselected and in read mode, everything else zero.
    localparam logic [INST_W-1:0] INST_IDLE =
        (34'd1 << INST_CEN_PMEM) | (34'd1 << INST_WEN_PMEM) |
        (34'd1 << INST_CEN_XMEM) | (34'd1 << INST_WEN_XMEM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W_RD  = 3'd1,
        S_K_LD  = 3'd2,
        S_K_GAP = 3'd3,
        S_X_RD  = 3'd4,
        S_EXEC  = 3'd5,
        S_P_WR  = 3'd6,
        S_DONE  = 3'd7
    } state_e;

endpackage

// File: rtl/seq_addr_gen.sv
// Base+offset address counter: clear, increment, terminal-count compare.
// Latency: addr_o/last_o combinational from the held count; count updates on the next edge.
// Backpressure: none; caller gates inc_i. Ports: base_i, last_i, clr_i (wins over inc_i), inc_i, addr_o, last_o.
module seq_addr_gen #(
    parameter int AW = 11,
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] base_i,
    input  logic [CW-1:0] last_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Wraps modulo 2^AW by construction.
    assign addr_o = base_i + AW'(cnt_q);
    assign last_o = (cnt_q == last_i);

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer feeding core.inst for a weight-stationary multi-tile run.
// Latency: inst is registered, so each action appears one cycle after the FSM decides it; ofifo_rd follows a sampled ofifo_valid by one cycle and the pmem write follows ofifo_rd by one more.
// Backpressure: waits indefinitely in P_WR while ofifo_valid=0; start ignored while busy. Optional CORE_SEQ_PERF_EN adds stall_cnt/run_cnt.
// Ports: clk, reset (sync, active-low), start, num_tiles, len, w_base, x_base, p_base, ofifo_valid -> inst[33:0], busy, done, err.
module core_inst_seq
    import core_pkg::*;
#(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int AW       = 11,
    parameter int LEN_W    = 11,
    parameter int TILE_W   = 4,
    parameter int L0_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [LEN_W-1:0]  len,
    input  logic [AW-1:0]     w_base,
    input  logic [AW-1:0]     x_base,
    input  logic [AW-1:0]     p_base,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       run_cnt
`endif
);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [TILE_W-1:0]   tile_q, tile_d, nt_q, nt_d;
    logic [LEN_W-1:0]    cyc_q, cyc_d, iss_q, iss_d, len_q, len_d;
    logic [AW-1:0]       wb_q, wb_d, xb_q, xb_d, pb_q, pb_d;

    logic                len_ok, accept, state_chg;
    logic [AW-1:0]       x_base_sel, x_addr, p_addr;
    logic [LEN_W-1:0]    x_last_sel;
    logic                x_last, p_last, xgen_inc;

    assign len_ok = (len != '0) && (len <= LEN_W'(L0_DEPTH));
    assign accept = (state_q == S_IDLE) && start && len_ok;

    // xmem reads weights for the current tile in W_RD and the shared activations in X_RD.
    assign x_base_sel = (state_q == S_X_RD) ? xb_q : (wb_q + AW'(tile_q) * AW'(col));
    assign x_last_sel = (state_q == S_X_RD) ? (len_q - 1'b1) : LEN_W'(col - 1);

    seq_addr_gen #(.AW(AW), .CW(LEN_W)) u_xgen (
        .clk    (clk),
        .reset  (reset),
        .base_i (x_base_sel),
        .last_i (x_last_sel),
        .clr_i  (state_chg),
        .inc_i  (xgen_inc),
        .addr_o (x_addr),
        .last_o (x_last)
    );

    // Counts pmem writes, which are the registered echo of ofifo_rd.
    seq_addr_gen #(.AW(AW), .CW(LEN_W)) u_pgen (
        .clk    (clk),
        .reset  (reset),
        .base_i (pb_q),
        .last_i (len_q - 1'b1),
        .clr_i  (state_chg && (state_d == S_P_WR)),
        .inc_i  (inst_q[INST_OFIFO_RD]),
        .addr_o (p_addr),
        .last_o (p_last)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        tile_d   = tile_q;
        iss_d    = iss_q;
        len_d    = len_q;
        nt_d     = nt_q;
        wb_d     = wb_q;
        xb_d     = xb_q;
        pb_d     = pb_q;
        xgen_inc = 1'b0;
        inst_d   = INST_IDLE;

        // SRAM Q lags its read by one cycle, so L0 captures on the echo of the read strobe.
        inst_d[INST_L0_WR] = ~inst_q[INST_CEN_XMEM];

        // The row popped from ofifo last cycle is on its data bus now; write it to pmem.
        if (inst_q[INST_OFIFO_RD]) begin
            inst_d[INST_CEN_PMEM] = 1'b0;
            inst_d[INST_WEN_PMEM] = 1'b0;
            inst_d[INST_APMEM_MSB:INST_APMEM_LSB] = p_addr;
            inst_d[INST_ACC] = (tile_q != '0);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        tile_d  = '0;
                        len_d   = len;
                        nt_d    = num_tiles;
                        wb_d    = w_base;
                        xb_d    = x_base;
                        pb_d    = p_base;
                        state_d = (num_tiles == '0) ? S_DONE : S_W_RD;
                    end
                end
            end
            S_W_RD, S_X_RD: begin
                inst_d[INST_CEN_XMEM] = 1'b0;
                inst_d[INST_AXMEM_MSB:INST_AXMEM_LSB] = x_addr;
                xgen_inc = 1'b1;
                if (x_last) begin
                    state_d = (state_q == S_W_RD) ? S_K_LD : S_EXEC;
                end
            end
            S_K_LD: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_LOAD]  = 1'b1;
                if (cyc_q == LEN_W'(col - 1)) state_d = S_K_GAP;
            end
            S_K_GAP: begin
                // Weights ripple across the array before the first activation arrives.
                if (cyc_q == LEN_W'(row + col - 1)) state_d = S_X_RD;
            end
            S_EXEC: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_EXEC]  = 1'b1;
                if (cyc_q == len_q - 1'b1) state_d = S_P_WR;
            end
            S_P_WR: begin
                if (ofifo_valid && (iss_q != len_q)) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    iss_d = iss_q + 1'b1;
                end
                // Leave on the edge that registers the last pmem write.
                if (inst_q[INST_OFIFO_RD] && p_last) begin
                    if (tile_q == nt_q - 1'b1) begin
                        state_d = S_DONE;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = S_W_RD;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        state_chg = (state_d != state_q);
        cyc_d = state_chg ? '0 : cyc_q + 1'b1;
        if (state_chg && (state_d == S_P_WR)) iss_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            inst_q  <= INST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tile_q  <= '0;
            nt_q    <= '0;
            cyc_q   <= '0;
            iss_q   <= '0;
            len_q   <= '0;
            wb_q    <= '0;
            xb_q    <= '0;
            pb_q    <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tile_q  <= tile_d;
            nt_q    <= nt_d;
            cyc_q   <= cyc_d;
            iss_q   <= iss_d;
            len_q   <= len_d;
            wb_q    <= wb_d;
            xb_q    <= xb_d;
            pb_q    <= pb_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

`ifdef CORE_SEQ_PERF_EN
    logic [15:0] stall_q, run_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            run_q   <= '0;
        end else if (accept) begin
            stall_q <= '0;
            run_q   <= '0;
        end else begin
            if ((state_q == S_P_WR) && !ofifo_valid && (stall_q != 16'hFFFF)) stall_q <= stall_q + 1'b1;
            if (busy_q && (run_q != 16'hFFFF)) run_q <= run_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign run_cnt   = run_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
